// File: rtl/phase_sequencer.sv
// Four-phase multicycle control sequencer: fetch / reg read / execute-mem / write back.
// Optional performance counters are enabled with `define PHASE_SEQUENCER_PERF_EN.
module phase_sequencer #(
    parameter int MEM_TIMEOUT = 15
`ifdef PHASE_SEQUENCER_PERF_EN
  , parameter int CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             mem_ready,
    input  logic             is_mem,
    input  logic             set_flags,
    input  logic             wb_en,
    input  logic             cond_pass,
    output logic [1:0]       phase,
    output logic             mem_req,
    output logic             ir_we,
    output logic             flags_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             busy,
    output logic             fault
`ifdef PHASE_SEQUENCER_PERF_EN
  , output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_REG, S_EXEC, S_WB, S_FAULT
    } state_t;

    localparam int               WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_q;
    logic            cond_q;
    logic            exec_first_q;
    logic            cond_eff;
    logic            exec_mem;
    logic            mem_wait;
    logic            timeout;

    // The condition is live from the flags unit only on the first EXEC cycle.
    assign cond_eff = exec_first_q ? cond_pass : cond_q;
    assign exec_mem = is_mem & cond_eff;
    assign mem_wait = mem_req & ~mem_ready;
    assign timeout  = mem_wait && (wait_q == WC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            cond_q       <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= (state_d == S_EXEC) && (state_q != S_EXEC);
            if (((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                ((state_d == S_EXEC)  && (state_q != S_EXEC)))
                wait_q <= '0;
            else if (mem_wait)
                wait_q <= wait_q + 1'b1;
            if ((state_q == S_EXEC) && exec_first_q)
                cond_q <= cond_pass;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_d = S_REG;
                else if (timeout) state_d = S_FAULT;
            end
            S_REG:   state_d = S_EXEC;
            S_EXEC: begin
                if (!exec_mem || mem_ready) state_d = S_WB;
                else if (timeout)           state_d = S_FAULT;
            end
            S_WB:    state_d = halt ? S_IDLE : S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are suppressed during a reset cycle so an aborted instruction writes nothing.
    always_comb begin
        phase    = 2'b00;
        busy     = 1'b0;
        fault    = 1'b0;
        mem_req  = 1'b0;
        ir_we    = 1'b0;
        flags_we = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy = 1'b1;
                if (!reset) begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
            end
            S_REG: begin
                phase = 2'b01;
                busy  = 1'b1;
            end
            S_EXEC: begin
                phase = 2'b10;
                busy  = 1'b1;
                if (!reset) begin
                    mem_req  = exec_mem;
                    flags_we = set_flags & cond_eff & (~exec_mem | mem_ready);
                end
            end
            S_WB: begin
                phase = 2'b11;
                busy  = 1'b1;
                if (!reset) begin
                    pc_we  = 1'b1;
                    reg_we = wb_en & cond_q;
                end
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

`ifdef PHASE_SEQUENCER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
            squash_cnt  <= '0;
        end else begin
            if (state_q == S_WB)            retired_cnt <= retired_cnt + 1'b1;
            if (mem_wait)                   stall_cnt   <= stall_cnt + 1'b1;
            if (state_q == S_WB && !cond_q) squash_cnt  <= squash_cnt + 1'b1;
        end
    end
`endif

endmodule
